// File: rtl/montgomery_mult_param.sv
// Radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M,
// one bit per clock plus a final conditional subtraction.
// Ports: clk, reset (async, active high), start, in_a, in_b, in_m,
//        result (registered), done (pulse), busy, err (pulse).
// Option: define MONT_MOD_CHECK_EN to reject an even or zero modulus.
module montgomery_mult_param #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    LOOP,
    SUB,
    ERR
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [WIDTH+1:0] c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bad_q;
  logic             mod_bad;

  logic [WIDTH+1:0] b_ext, m_ext;
  logic [WIDTH+1:0] t_add, t_red, c_next;
  logic [WIDTH+1:0] c_sub;
  logic [WIDTH-1:0] fin;

`ifdef MONT_MOD_CHECK_EN
  // in_m == 0 is already covered by an even LSB
  assign mod_bad = ~in_m[0];
`else
  assign mod_bad = 1'b0;
`endif

  assign b_ext = {2'b00, b_q};
  assign m_ext = {2'b00, m_q};

  // C < 2M and B < M keep T below 4M, so WIDTH+2 bits never overflow
  always_comb begin
    t_add  = c_q + (a_q[0] ? b_ext : '0);
    t_red  = t_add[0] ? t_add + m_ext : t_add;
    c_next = t_red >> 1;
    c_sub  = c_q - m_ext;
    fin    = (c_q >= m_ext) ? c_sub[WIDTH-1:0]
                            : c_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = mod_bad ? ERR : LOOP;
      LOOP: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = SUB;
      SUB:  state_d = IDLE;
      ERR:  state_d = SUB;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == LOOP) || (state_q == ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      err     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            c_q   <= '0;
            cnt_q <= '0;
            bad_q <= mod_bad;
          end
        end
        LOOP: begin
          c_q   <= c_next;
          // multiplier bits consumed LSB first
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        SUB: begin
          result <= bad_q ? '0 : fin;
          done   <= 1'b1;
          err    <= bad_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Directed bench for montgomery_mult_param at WIDTH=8.
// Expected products are hand-computed A*B*2^-8 mod M.
module tb_montgomery_mult_param;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] in_a, in_b, in_m;
  logic [W-1:0] result;
  logic         done, busy, err;

  int checks = 0;
  int errors = 0;

  montgomery_mult_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .in_m  (in_m),
    .result(result),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] m);
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    in_m  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_n);
    cyc    = 0;
    busy_n = busy ? 1 : 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    in_m  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result !== 8'd0) begin
      errors++;
      $display("FAIL reset_result got %0d want 0", result);
    end
    checks++;
    if ({done, busy, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
               {done, busy, err});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int cyc, bn;
    start_op(8'd3, 8'd5, 8'd13);
    wait_done(cyc, bn);
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL basic_latency got %0d want 9", cyc);
    end
    checks++;
    if (result !== 8'd6) begin
      errors++;
      $display("FAIL basic_result got %0d want 6", result);
    end
    checks++;
    if (bn !== 8) begin
      errors++;
      $display("FAIL basic_busy got %0d want 8", bn);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err got %b want 0", err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got %b want 0", done);
    end
    checks++;
    if (result !== 8'd6) begin
      errors++;
      $display("FAIL result_hold got %0d want 6", result);
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] va [7] = '{8'd254, 8'd0, 8'd12, 8'd1,
                             8'd2, 8'd0, 8'd200};
    logic [W-1:0] vb [7] = '{8'd254, 8'd200, 8'd12, 8'd12,
                             8'd3, 8'd0, 8'd0};
    logic [W-1:0] vm [7] = '{8'd255, 8'd255, 8'd13, 8'd13,
                             8'd251, 8'd1, 8'd255};
    logic [W-1:0] ve [7] = '{8'd1, 8'd0, 8'd3, 8'd10,
                             8'd202, 8'd0, 8'd0};
    int cyc, bn;
    for (int i = 0; i < 7; i++) begin
      start_op(va[i], vb[i], vm[i]);
      wait_done(cyc, bn);
      checks++;
      if (cyc !== 9 || result !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d got %0d@%0d want %0d@9",
                 i, result, cyc, ve[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int cyc, bn;
    start_op(8'd3, 8'd5, 8'd13);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_a  = 8'd1;
    in_b  = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bn);
    checks++;
    if (cyc + 3 !== 9 || result !== 8'd6) begin
      errors++;
      $display("FAIL ignore_busy got %0d@%0d want 6@9",
               result, cyc + 3);
    end
    in_a  = 8'd1;
    in_b  = 8'd1;
    in_m  = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || result !== 8'd6) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b res=%0d want 1 6",
               busy, result);
    end
    wait_done(cyc, bn);
    checks++;
    if (cyc !== 9 || result !== 8'd3) begin
      errors++;
      $display("FAIL b2b_result got %0d@%0d want 3@9",
               result, cyc);
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2, bn;
    @(negedge clk);
    in_a  = 8'd3;
    in_b  = 8'd5;
    in_m  = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(c1, bn);
    checks++;
    if (c1 !== 9 || result !== 8'd6) begin
      errors++;
      $display("FAIL hold_first got %0d@%0d want 6@9",
               result, c1);
    end
    in_a = 8'd12;
    in_b = 8'd12;
    wait_done(c2, bn);
    start = 1'b0;
    checks++;
    if (c2 !== 10 || result !== 8'd3) begin
      errors++;
      $display("FAIL hold_second got %0d@%0d want 3@10",
               result, c2);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, bn, dn;
    start_op(8'd3, 8'd5, 8'd13);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (result !== 8'd0 || {done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset got res=%0d db=%b want 0 00",
               result, {done, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d want 0", dn);
    end
    start_op(8'd12, 8'd12, 8'd13);
    wait_done(cyc, bn);
    checks++;
    if (cyc !== 9 || result !== 8'd3) begin
      errors++;
      $display("FAIL mid_recover got %0d@%0d want 3@9",
               result, cyc);
    end
  endtask

  task automatic test_mod_check;
    int cyc, bn;
    start_op(8'd3, 8'd5, 8'd8);
    wait_done(cyc, bn);
`ifdef MONT_MOD_CHECK_EN
    checks++;
    if (cyc !== 2 || err !== 1'b1 || result !== 8'd0) begin
      errors++;
      $display("FAIL modchk got %0d err=%b res=%0d want 2 1 0",
               cyc, err, result);
    end
`else
    checks++;
    if (cyc !== 9 || err !== 1'b0) begin
      errors++;
      $display("FAIL modchk got %0d err=%b want 9 0", cyc, err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_mod_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
